// File: rtl/riscv_csr_trap_if.sv
`default_nettype none
// ============================================================================
// riscv_csr_trap_if : core <-> CSR/trap unit signal bundle
// Rev 1.0
// ============================================================================
interface riscv_csr_trap_if #(
   parameter int unsigned XLEN = 32
);
   logic [11:0]     csr_addr;
   logic [1:0]      csr_op;
   logic [XLEN-1:0] csr_wdata;
   logic [XLEN-1:0] csr_rdata;
   logic            instr_retire;
   logic            ecall;
   logic            ebreak;
   logic            mret;
   logic [XLEN-1:0] pc;
   logic            irq_timer;
   logic            irq_ext;
   logic            trap_taken;
   logic            redirect;
   logic [XLEN-1:0] trap_pc;

   modport master (
      output csr_addr, csr_op, csr_wdata, instr_retire, ecall, ebreak, mret, pc,
             irq_timer, irq_ext,
      input  csr_rdata, trap_taken, redirect, trap_pc
   );

   modport slave (
      input  csr_addr, csr_op, csr_wdata, instr_retire, ecall, ebreak, mret, pc,
             irq_timer, irq_ext,
      output csr_rdata, trap_taken, redirect, trap_pc
   );
endinterface
`default_nettype wire

// File: rtl/riscv_csr_trap.sv
`default_nettype none
// ============================================================================
// riscv_csr_trap : machine-mode CSR file, interrupt/exception entry and MRET
// Rev 1.0
// ============================================================================
module riscv_csr_trap #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned HART_ID     = 0,
   parameter logic [31:0] MTVEC_RESET = 32'h0,
   parameter bit          VECTORED    = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   riscv_csr_trap_if.slave  core_io
);
   localparam logic [11:0] c_MSTATUS   = 12'h300;
   localparam logic [11:0] c_MISA      = 12'h301;
   localparam logic [11:0] c_MIE       = 12'h304;
   localparam logic [11:0] c_MTVEC     = 12'h305;
   localparam logic [11:0] c_MSCRATCH  = 12'h340;
   localparam logic [11:0] c_MEPC      = 12'h341;
   localparam logic [11:0] c_MCAUSE    = 12'h342;
   localparam logic [11:0] c_MTVAL     = 12'h343;
   localparam logic [11:0] c_MIP       = 12'h344;
   localparam logic [11:0] c_MCYCLE    = 12'hB00;
   localparam logic [11:0] c_MINSTRET  = 12'hB02;
   localparam logic [11:0] c_MCYCLEH   = 12'hB80;
   localparam logic [11:0] c_MINSTRETH = 12'hB82;
   localparam logic [11:0] c_MHARTID   = 12'hF14;

   localparam logic [1:0] c_OP_NONE = 2'b00;
   localparam logic [1:0] c_OP_RW   = 2'b01;
   localparam logic [1:0] c_OP_RS   = 2'b10;

   localparam logic [1:0]      c_MXL        = (XLEN == 64) ? 2'd2 : 2'd1;
   localparam logic [XLEN-1:0] c_MISA_VAL   = {c_MXL, {(XLEN-11){1'b0}}, 1'b1, 8'h00};
   localparam logic [XLEN-1:0] c_MTVEC_MASK = VECTORED ? ~XLEN'(2) : ~XLEN'(3);
   localparam logic [XLEN-1:0] c_MTVEC_RST  = XLEN'(MTVEC_RESET) & c_MTVEC_MASK;
   localparam logic [63:0]     c_LO_MASK    = (XLEN == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
   localparam logic [XLEN-1:0] c_INT_BIT    = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] c_CAUSE_MEI  = c_INT_BIT | XLEN'(11);
   localparam logic [XLEN-1:0] c_CAUSE_MTI  = c_INT_BIT | XLEN'(7);

   logic            mie_q, mie_d, mpie_q, mpie_d;
   logic            mtie_q, mtie_d, meie_q, meie_d;
   logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
   logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
   logic [63:0]     mcycle_q, mcycle_d, minstret_q, minstret_d;
   logic            tim_s1_q, tim_s2_q, ext_s1_q, ext_s2_q;

   logic [XLEN-1:0] w_mstatus, w_mie_rd, w_mip_rd, w_rdata_raw, w_wval;
   logic [XLEN-1:0] w_cause, w_base, w_epc, w_trap_pc;
   logic            w_impl, w_op_act, w_ro, w_illegal, w_int_pend, w_is_int;
   logic            w_trap, w_mret_ok, w_we;

   // Read side: old value of the addressed CSR plus whether the address exists.
   always_comb begin
      w_mstatus         = '0;
      w_mstatus[3]      = mie_q;
      w_mstatus[7]      = mpie_q;
      w_mstatus[12:11]  = 2'b11;
      w_mie_rd          = '0;
      w_mie_rd[7]       = mtie_q;
      w_mie_rd[11]      = meie_q;
      w_mip_rd          = '0;
      w_mip_rd[7]       = tim_s2_q;
      w_mip_rd[11]      = ext_s2_q;
      w_impl            = 1'b1;
      w_rdata_raw       = '0;
      case (core_io.csr_addr)
         c_MSTATUS:   w_rdata_raw = w_mstatus;
         c_MISA:      w_rdata_raw = c_MISA_VAL;
         c_MIE:       w_rdata_raw = w_mie_rd;
         c_MTVEC:     w_rdata_raw = mtvec_q;
         c_MSCRATCH:  w_rdata_raw = mscratch_q;
         c_MEPC:      w_rdata_raw = {mepc_q[XLEN-1:2], 2'b00};
         c_MCAUSE:    w_rdata_raw = mcause_q;
         c_MTVAL:     w_rdata_raw = mtval_q;
         c_MIP:       w_rdata_raw = w_mip_rd;
         c_MCYCLE:    w_rdata_raw = mcycle_q[XLEN-1:0];
         c_MINSTRET:  w_rdata_raw = minstret_q[XLEN-1:0];
         c_MCYCLEH: begin
            w_rdata_raw = XLEN'(mcycle_q[63:32]);
            w_impl      = (XLEN == 32);
         end
         c_MINSTRETH: begin
            w_rdata_raw = XLEN'(minstret_q[63:32]);
            w_impl      = (XLEN == 32);
         end
         c_MHARTID:   w_rdata_raw = XLEN'(HART_ID);
         default:     w_impl      = 1'b0;
      endcase
   end

   assign w_op_act   = (core_io.csr_op != c_OP_NONE);
   assign w_ro       = (core_io.csr_addr[11:10] == 2'b11);
   assign w_illegal  = w_op_act & (~w_impl |
                       (w_ro & ((core_io.csr_op == c_OP_RW) | (|core_io.csr_wdata))));
   assign w_int_pend = mie_q & ((ext_s2_q & meie_q) | (tim_s2_q & mtie_q));
   assign w_trap     = ~rst & (w_int_pend | w_illegal | core_io.ebreak | core_io.ecall);
   assign w_mret_ok  = ~rst & core_io.mret & ~w_trap;
   assign w_we       = ~rst & w_op_act & ~w_illegal & ~w_trap;
   assign w_base     = {mtvec_q[XLEN-1:2], 2'b00};
   assign w_epc      = {mepc_q[XLEN-1:2], 2'b00};

   always_comb begin
      w_is_int = 1'b0;
      w_cause  = '0;
      if (w_int_pend) begin
         w_is_int = 1'b1;
         w_cause  = (ext_s2_q & meie_q) ? c_CAUSE_MEI : c_CAUSE_MTI;
      end else if (w_illegal) begin
         w_cause  = XLEN'(2);
      end else if (core_io.ebreak) begin
         w_cause  = XLEN'(3);
      end else begin
         w_cause  = XLEN'(11);
      end
   end

   // Shifting by two drops the interrupt flag, leaving 4*cause code.
   always_comb begin
      w_trap_pc = '0;
      if (w_trap) begin
         w_trap_pc = (w_is_int && mtvec_q[0]) ? (w_base + (w_cause << 2)) : w_base;
      end else if (w_mret_ok) begin
         w_trap_pc = w_epc;
      end
   end

   always_comb begin
      case (core_io.csr_op)
         c_OP_RW: w_wval = core_io.csr_wdata;
         c_OP_RS: w_wval = w_rdata_raw | core_io.csr_wdata;
         default: w_wval = w_rdata_raw & ~core_io.csr_wdata;
      endcase
   end

   always_comb begin
      mie_d      = mie_q;
      mpie_d     = mpie_q;
      mtie_d     = mtie_q;
      meie_d     = meie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mtval_d    = mtval_q;
      mcycle_d   = mcycle_q + 64'd1;
      minstret_d = minstret_q + 64'(core_io.instr_retire & ~w_trap);
      if (w_we) begin
         case (core_io.csr_addr)
            c_MSTATUS: begin
               mie_d  = w_wval[3];
               mpie_d = w_wval[7];
            end
            c_MIE: begin
               mtie_d = w_wval[7];
               meie_d = w_wval[11];
            end
            c_MTVEC:     mtvec_d    = w_wval & c_MTVEC_MASK;
            c_MSCRATCH:  mscratch_d = w_wval;
            c_MEPC:      mepc_d     = w_wval;
            c_MCAUSE:    mcause_d   = w_wval;
            c_MTVAL:     mtval_d    = w_wval;
            // A counter write replaces the increment; the other half keeps its old value.
            c_MCYCLE:    mcycle_d   = (mcycle_q & ~c_LO_MASK) | 64'(w_wval);
            c_MCYCLEH:   mcycle_d   = {w_wval[31:0], mcycle_q[31:0]};
            c_MINSTRET:  minstret_d = (minstret_q & ~c_LO_MASK) | 64'(w_wval);
            c_MINSTRETH: minstret_d = {w_wval[31:0], minstret_q[31:0]};
            default: ;
         endcase
      end
      if (w_trap) begin
         mepc_d   = core_io.pc;
         mcause_d = w_cause;
         mtval_d  = '0;
         mpie_d   = mie_q;
         mie_d    = 1'b0;
      end else if (w_mret_ok) begin
         mie_d    = mpie_q;
         mpie_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         mtie_q     <= 1'b0;
         meie_q     <= 1'b0;
         mtvec_q    <= c_MTVEC_RST;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
         mcycle_q   <= '0;
         minstret_q <= '0;
         tim_s1_q   <= 1'b0;
         tim_s2_q   <= 1'b0;
         ext_s1_q   <= 1'b0;
         ext_s2_q   <= 1'b0;
      end else begin
         mie_q      <= mie_d;
         mpie_q     <= mpie_d;
         mtie_q     <= mtie_d;
         meie_q     <= meie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mtval_q    <= mtval_d;
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
         tim_s1_q   <= core_io.irq_timer;
         tim_s2_q   <= tim_s1_q;
         ext_s1_q   <= core_io.irq_ext;
         ext_s2_q   <= ext_s1_q;
      end
   end

   assign core_io.csr_rdata  = (~rst & w_op_act & ~w_illegal) ? w_rdata_raw : '0;
   assign core_io.trap_taken = w_trap;
   assign core_io.redirect   = w_trap | w_mret_ok;
   assign core_io.trap_pc    = w_trap_pc;

endmodule
`default_nettype wire

// File: tb/tb_riscv_csr_trap.sv
`default_nettype none
// ============================================================================
// tb_riscv_csr_trap : directed + random checks of riscv_csr_trap against a model
// Rev 1.0
// ============================================================================
module tb_riscv_csr_trap;
   logic clk;
   logic rst;
   logic rst2;
   int   n_assert;
   int   n_fail;

   riscv_csr_trap_if #(.XLEN(32)) bus  ();
   riscv_csr_trap_if #(.XLEN(32)) bus2 ();

   riscv_csr_trap #(
      .XLEN(32), .HART_ID(5), .MTVEC_RESET(32'h0000_0203), .VECTORED(1'b1)
   ) u_dut (
      .clk(clk), .rst(rst), .core_io(bus)
   );

   riscv_csr_trap #(
      .XLEN(32), .HART_ID(0), .MTVEC_RESET(32'h0), .VECTORED(1'b0)
   ) u_dut_nv (
      .clk(clk), .rst(rst2), .core_io(bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference state, held as architectural values.
   bit              m_mie_b, m_mpie_b;
   logic [31:0]     m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
   longint unsigned m_cycle, m_instret;
   bit              tim_h [2];
   bit              ext_h [2];

   logic [31:0] g_pc;
   logic        g_it, g_ie;
   logic [31:0] o_rdata, o_tpc;
   logic        o_trap, o_redir;
   logic [31:0] o2_rdata, o2_tpc;
   logic        o2_trap;
   logic [11:0] addrs [16];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit m_read(input logic [11:0] a, output logic [31:0] v);
      v = 32'h0;
      case (a)
         12'h300: v = 32'h1800 | (32'(m_mpie_b) << 7) | (32'(m_mie_b) << 3);
         12'h301: v = 32'h4000_0100;
         12'h304: v = m_mie;
         12'h305: v = m_mtvec;
         12'h340: v = m_mscratch;
         12'h341: v = m_mepc & ~32'h3;
         12'h342: v = m_mcause;
         12'h343: v = m_mtval;
         12'h344: v = (32'(ext_h[1]) << 11) | (32'(tim_h[1]) << 7);
         12'hB00: v = m_cycle[31:0];
         12'hB02: v = m_instret[31:0];
         12'hB80: v = 32'(m_cycle >> 32);
         12'hB82: v = 32'(m_instret >> 32);
         12'hF14: v = 32'd5;
         default: return 1'b0;
      endcase
      return 1'b1;
   endfunction

   task automatic model_reset();
      m_mie_b = 0; m_mpie_b = 0; m_mie = 0; m_mtvec = 32'h203 & ~32'h2;
      m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
      m_cycle = 0; m_instret = 0;
      tim_h[0] = 0; tim_h[1] = 0; ext_h[0] = 0; ext_h[1] = 0;
   endtask

   task automatic model_step(input logic r, input logic [11:0] a, input logic [1:0] op,
                             input logic [31:0] wd, input logic ret, input logic ec,
                             input logic eb, input logic mr,
                             output logic [31:0] e_rd, output logic e_trap,
                             output logic e_redir, output logic [31:0] e_tpc);
      logic [31:0] old, nv, mip, cause, base;
      bit exists, illegal, pending, is_int, trap, mret_ok, we, old_mie, old_mpie;
      longint unsigned cyc_n, ins_n;
      e_rd = 0; e_trap = 0; e_redir = 0; e_tpc = 0;
      if (r) begin
         model_reset();
         return;
      end
      exists  = m_read(a, old);
      illegal = (op != 2'b00) && (!exists || (a[11:10] == 2'b11 && (op == 2'b01 || wd != 0)));
      void'(m_read(12'h344, mip));
      pending = m_mie_b && ((mip & m_mie) != 0);
      is_int  = pending;
      if (pending)      cause = ((mip & m_mie & 32'h800) != 0) ? 32'h8000_000B : 32'h8000_0007;
      else if (illegal) cause = 2;
      else if (eb)      cause = 3;
      else              cause = 11;
      trap    = pending || illegal || eb || ec;
      mret_ok = mr && !trap;
      base    = m_mtvec & ~32'h3;
      if (trap)         e_tpc = (is_int && m_mtvec[0]) ? base + 4 * (cause & 32'h7FFF_FFFF) : base;
      else if (mret_ok) e_tpc = m_mepc & ~32'h3;
      e_trap  = trap;
      e_redir = trap || mret_ok;
      e_rd    = (op != 2'b00 && !illegal) ? old : 32'h0;

      old_mie  = m_mie_b;
      old_mpie = m_mpie_b;
      cyc_n = m_cycle + 1;
      ins_n = m_instret + ((ret && !trap) ? 1 : 0);
      we = (op != 2'b00) && !illegal && !trap;
      nv = (op == 2'b01) ? wd : (op == 2'b10) ? (old | wd) : (old & ~wd);
      if (we) begin
         case (a)
            12'h300: begin m_mie_b = nv[3]; m_mpie_b = nv[7]; end
            12'h304: m_mie = nv & 32'h880;
            12'h305: m_mtvec = nv & ~32'h2;
            12'h340: m_mscratch = nv;
            12'h341: m_mepc = nv;
            12'h342: m_mcause = nv;
            12'h343: m_mtval = nv;
            12'hB00: cyc_n = (m_cycle & 64'hFFFF_FFFF_0000_0000) | 64'(nv);
            12'hB80: cyc_n = (m_cycle & 64'h0000_0000_FFFF_FFFF) | (64'(nv) << 32);
            12'hB02: ins_n = (m_instret & 64'hFFFF_FFFF_0000_0000) | 64'(nv);
            12'hB82: ins_n = (m_instret & 64'h0000_0000_FFFF_FFFF) | (64'(nv) << 32);
            default: ;
         endcase
      end
      if (trap) begin
         m_mepc = g_pc; m_mcause = cause; m_mtval = 0;
         m_mpie_b = old_mie; m_mie_b = 0;
      end else if (mret_ok) begin
         m_mie_b = old_mpie; m_mpie_b = 1;
      end
      m_cycle   = cyc_n;
      m_instret = ins_n;
      tim_h[1] = tim_h[0]; tim_h[0] = g_it;
      ext_h[1] = ext_h[0]; ext_h[0] = g_ie;
   endtask

   // One clock cycle on the main DUT: drive, check against the model, advance.
   task automatic step(input logic r, input logic [11:0] a, input logic [1:0] op,
                       input logic [31:0] wd, input logic ret, input logic ec,
                       input logic eb, input logic mr);
      logic [31:0] e_rd, e_tpc;
      logic        e_trap, e_redir;
      rst = r;
      bus.csr_addr = a; bus.csr_op = op; bus.csr_wdata = wd;
      bus.instr_retire = ret; bus.ecall = ec; bus.ebreak = eb; bus.mret = mr;
      bus.pc = g_pc; bus.irq_timer = g_it; bus.irq_ext = g_ie;
      #2;
      o_rdata = bus.csr_rdata; o_trap = bus.trap_taken;
      o_redir = bus.redirect;  o_tpc  = bus.trap_pc;
      model_step(r, a, op, wd, ret, ec, eb, mr, e_rd, e_trap, e_redir, e_tpc);
      chk("rdata", o_rdata, e_rd);
      chk("trap_taken", 32'(o_trap), 32'(e_trap));
      chk("redirect", 32'(o_redir), 32'(e_redir));
      chk("trap_pc", o_tpc, e_tpc);
      @(negedge clk);
   endtask

   task automatic idle();
      step(0, 12'h000, 2'b00, 0, 0, 0, 0, 0);
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] wd);
      step(0, a, 2'b01, wd, 0, 0, 0, 0);
   endtask

   task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
      step(0, a, 2'b10, 0, 0, 0, 0, 0);
      chk(tag, o_rdata, exp);
   endtask

   task automatic cyc2(input logic r, input logic [11:0] a, input logic [1:0] op,
                       input logic [31:0] wd, input logic it);
      rst2 = r;
      bus2.csr_addr = a; bus2.csr_op = op; bus2.csr_wdata = wd; bus2.irq_timer = it;
      #2;
      o2_rdata = bus2.csr_rdata; o2_trap = bus2.trap_taken; o2_tpc = bus2.trap_pc;
      @(negedge clk);
   endtask

   initial begin
      n_assert = 0; n_fail = 0;
      rst = 1'b1; rst2 = 1'b1;
      g_pc = 32'h0; g_it = 1'b0; g_ie = 1'b0;
      bus.csr_addr = '0; bus.csr_op = '0; bus.csr_wdata = '0; bus.instr_retire = 1'b0;
      bus.ecall = 1'b0; bus.ebreak = 1'b0; bus.mret = 1'b0; bus.pc = '0;
      bus.irq_timer = 1'b0; bus.irq_ext = 1'b0;
      bus2.csr_addr = '0; bus2.csr_op = '0; bus2.csr_wdata = '0; bus2.instr_retire = 1'b0;
      bus2.ecall = 1'b0; bus2.ebreak = 1'b0; bus2.mret = 1'b0; bus2.pc = '0;
      bus2.irq_timer = 1'b0; bus2.irq_ext = 1'b0;
      addrs = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF14, 12'h7C0, 12'h000};
      model_reset();
      @(negedge clk);

      // Reset: all outputs 0, even with an ecall presented.
      step(1, 12'h300, 2'b01, 32'hFFFF_FFFF, 1, 1, 0, 0);
      chk("reset_trap", 32'(o_trap), 32'h0);
      step(1, 12'h000, 2'b00, 0, 0, 0, 0, 0);
      rd("mcycle_after_reset", 12'hB00, 32'h0);
      rd("mtvec_reset", 12'h305, 32'h201);

      // External interrupt, non-vectored target.
      wr(12'h305, 32'h100);
      wr(12'h304, 32'h800);
      wr(12'h300, 32'h8);
      g_ie = 1'b1; g_pc = 32'h1F8;
      idle(); chk("irq_sync_1", 32'(o_trap), 32'h0);
      idle(); chk("irq_sync_2", 32'(o_trap), 32'h0);
      g_pc = 32'h200;
      idle();
      chk("mei_trap", 32'(o_trap), 32'h1);
      chk("mei_trap_pc", o_tpc, 32'h100);
      g_pc = 32'h100;
      rd("mei_mcause", 12'h342, 32'h8000_000B);
      rd("mei_mepc", 12'h341, 32'h200);
      rd("mei_mstatus", 12'h300, 32'h1880);

      // Timer interrupt with vectored mtvec.
      wr(12'h305, 32'h101);
      g_ie = 1'b0;
      wr(12'h304, 32'h80);
      g_it = 1'b1;
      idle(); idle();
      wr(12'h300, 32'h8);
      g_pc = 32'h240;
      idle();
      chk("mti_trap", 32'(o_trap), 32'h1);
      chk("mti_vector_pc", o_tpc, 32'h11C);
      g_it = 1'b0;
      idle(); idle(); idle();
      rd("mti_mcause", 12'h342, 32'h8000_0007);

      // ECALL then MRET.
      g_pc = 32'h8000_0010;
      step(0, 12'h000, 2'b00, 0, 0, 1, 0, 0);
      chk("ecall_redirect", 32'(o_redir), 32'h1);
      chk("ecall_pc", o_tpc, 32'h100);
      g_pc = 32'h100;
      rd("ecall_mcause", 12'h342, 32'd11);
      wr(12'h300, 32'h80);
      step(0, 12'h000, 2'b00, 0, 0, 0, 0, 1);
      chk("mret_redirect", 32'(o_redir), 32'h1);
      chk("mret_pc", o_tpc, 32'h8000_0010);
      rd("mret_mstatus", 12'h300, 32'h1888);

      // Illegal CSR accesses.
      wr(12'hF14, 32'h55);
      chk("hartid_rw_trap", 32'(o_trap), 32'h1);
      rd("illegal_mcause", 12'h342, 32'd2);
      rd("mhartid", 12'hF14, 32'd5);
      chk("mhartid_legal", 32'(o_trap), 32'h0);
      wr(12'h342, 32'h77);
      step(0, 12'h7C0, 2'b10, 32'h1, 0, 0, 0, 0);
      chk("unimpl_trap", 32'(o_trap), 32'h1);
      rd("unimpl_mcause", 12'h342, 32'd2);

      // mcycle carry into the high word.
      wr(12'hB00, 32'hFFFF_FFFF);
      wr(12'hB80, 32'h0);
      idle();
      rd("mcycle_wrap_lo", 12'hB00, 32'h0);
      rd("mcycle_wrap_hi", 12'hB80, 32'h1);

      // Retire alongside ECALL: no minstret step, CSR write suppressed.
      wr(12'hB02, 32'h50);
      wr(12'h340, 32'h1234);
      step(0, 12'h340, 2'b01, 32'hDEAD, 1, 1, 0, 0);
      chk("ecall_retire_trap", 32'(o_trap), 32'h1);
      rd("minstret_held", 12'hB02, 32'h50);
      rd("mscratch_held", 12'h340, 32'h1234);

      // Reset arriving in a trap cycle.
      g_pc = 32'h300;
      step(1, 12'h000, 2'b00, 0, 0, 1, 0, 0);
      chk("rst_trap_masked", 32'(o_trap), 32'h0);
      rd("rst_mepc", 12'h341, 32'h0);
      rd("rst_mcause", 12'h342, 32'h0);

      // Random traffic checked cycle by cycle against the model.
      for (int i = 0; i < 1500; i++) begin
         logic [11:0] a;
         logic [31:0] wd;
         addrs[15] = 12'($urandom);
         a  = addrs[$urandom_range(0, 15)];
         wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         g_pc = $urandom & ~32'h3;
         if ($urandom_range(0, 7) == 0) g_it = ~g_it;
         if ($urandom_range(0, 7) == 0) g_ie = ~g_ie;
         step(($urandom_range(0, 63) == 0), a, 2'($urandom_range(0, 3)), wd,
              1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
      end

      // Non-vectored instance: mode bits hardwired to zero.
      cyc2(1, 12'h000, 2'b00, 0, 0);
      cyc2(0, 12'h305, 2'b01, 32'h101, 0);
      cyc2(0, 12'h305, 2'b10, 32'h0, 0);
      chk("nv_mtvec", o2_rdata, 32'h100);
      cyc2(0, 12'h304, 2'b01, 32'h80, 1);
      cyc2(0, 12'h000, 2'b00, 0, 1);
      cyc2(0, 12'h000, 2'b00, 0, 1);
      cyc2(0, 12'h300, 2'b01, 32'h8, 1);
      chk("nv_no_early_trap", 32'(o2_trap), 32'h0);
      cyc2(0, 12'h000, 2'b00, 0, 1);
      chk("nv_mti_trap", 32'(o2_trap), 32'h1);
      chk("nv_mti_pc", o2_tpc, 32'h100);
      cyc2(0, 12'h342, 2'b10, 32'h0, 0);
      chk("nv_mcause", o2_rdata, 32'h8000_0007);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
